// File: rtl/uart_read_fifo_if.sv
// Receive-side bus of the buffered UART reader:
// serial line in, FWFT byte queue and sticky error flags out.
interface uart_read_fifo_if;
  logic       rx;
  logic       read;
  logic       clear_err;
  logic       arrived;
  logic [7:0] data;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rx,
    output read,
    output clear_err,
    input  arrived,
    input  data,
    input  overrun,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  read,
    input  clear_err,
    output arrived,
    output data,
    output overrun,
    output frame_err
  );
endinterface

// File: rtl/uart_read_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO,
// with sticky overrun / framing-error flags.
module uart_read_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  uart_read_fifo_if.slave bus
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL =
    (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;
  logic [7:0]            mem_q [DEPTH];

  logic push, ferr_set, pop, push_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still takes the byte when the head leaves the same edge.
  always_comb begin
    pop     = bus.read && (count_q != '0);
    push_ok = push && ((count_q != FULL) || pop);
    wptr_d  = wptr_q + DEPTH_LOG2'(push_ok);
    rptr_d  = rptr_q + DEPTH_LOG2'(pop);
    count_d = count_q
            + (DEPTH_LOG2 + 1)'(push_ok)
            - (DEPTH_LOG2 + 1)'(pop);
    ovr_d   = (push && !push_ok) || (ovr_q && !bus.clear_err);
    ferr_d  = ferr_set || (ferr_q && !bus.clear_err);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  assign bus.arrived   = (count_q != '0);
  assign bus.data      = bus.arrived ? mem_q[rptr_q] : 8'h00;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_read_fifo.sv
// Bench for uart_read_fifo: directed frames plus random traffic,
// checked against a byte-queue model of the receiver.
module tb_uart_read_fifo;
  localparam int CPB = 8;
  localparam int NF  = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_read_fifo_if bus ();

  uart_read_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  byte unsigned q[$];
  bit          m_ovr;
  bit          m_ferr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".arrived"}, 32'(bus.arrived),
          32'(q.size() != 0));
    check({tag, ".data"}, 32'(bus.data),
          q.size() != 0 ? 32'(q[0]) : 32'd0);
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; optional read / clear_err on the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit rd, input bit clr);
    for (int k = 0; k < NF; k++) begin
      @(negedge clk);
      if (k == NF - 2) begin
        check_state("pre_stop");
        bus.read      = rd;
        bus.clear_err = clr;
      end else begin
        bus.read      = 1'b0;
        bus.clear_err = 1'b0;
      end
      if (k < CPB) bus.rx = 1'b0;
      else if (k < 9 * CPB) bus.rx = b[k/CPB-1];
      else bus.rx = stop;
    end
    if (rd && q.size() != 0) void'(q.pop_front());
    if (clr) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
    if (!stop) m_ferr = 1'b1;
    else if (q.size() < 4) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk);
    check_state("pre_read");
    bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_state("post_read");
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    check_state("post_clear");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.rx        = 1'b1;
    bus.read      = 1'b0;
    bus.clear_err = 1'b0;
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    @(negedge clk);
    check_state("in_reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] pb;
    logic       st;
    int         gap;

    bus.rx        = 1'b1;
    bus.read      = 1'b0;
    bus.clear_err = 1'b0;
    m_ovr         = 1'b0;
    m_ferr        = 1'b0;

    repeat (3) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    idle(100);
    check_state("idle100");

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_state("a5");
    pop_one();

    @(negedge clk);
    bus.rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check_state("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check_state("3c");
    pop_one();

    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check_state("break_stop");
    repeat (20) @(negedge clk);
    clear_pulse();
    repeat (20) @(negedge clk);
    check_state("break_hold");
    idle(10);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check_state("81");
    pop_one();

    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    check_state("fill5");
    repeat (4) pop_one();
    check_state("drain4");
    idle(5);
    clear_pulse();

    for (int i = 1; i <= 4; i++)
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1, 1'b0);
    check_state("full_pop_push");
    repeat (4) pop_one();
    check_state("drain_b");

    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle(5);
    check_state("set_wins");
    clear_pulse();

    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    pb = 8'h77;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.rx = (k < CPB) ? 1'b0 : pb[k/CPB-1];
    end
    do_reset();
    idle(5);
    check_state("post_reset");
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    check_state("f0");
    pop_one();

    repeat (60) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send_frame(b, st, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
      check_state("rnd");
      gap = st ? int'($urandom_range(0, 3))
               : int'($urandom_range(4, 10));
      idle(gap);
      repeat ($urandom_range(0, 3)) pop_one();
      if ($urandom_range(0, 5) == 0) clear_pulse();
    end
    while (q.size() != 0) pop_one();
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_read_fifo.md
# uart_read_fifo

Buffered UART receiver: deserializes 8N1 frames from a serial line, validates start/stop bits, and queues received bytes in a small first-word-fall-through FIFO. It is the receive-side counterpart to the existing byte writer (ready/send/finish) and lets a consumer drain bytes at its own pace instead of catching a one-cycle arrival pulse. Sticky overrun and framing flags report lost or corrupt frames.

## Interface
- CLKS_PER_BIT, default 868, clock cycles per bit period (100 MHz / 115200 baud); legal range ≥ 4.
- DEPTH_LOG2, default 2, log2 of FIFO depth (default 4 entries); legal range ≥ 1.
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- RX  input  1  serial line; idle high; asynchronous to Clock.
- arrived  output  1  high while the FIFO is non-empty.
- data  output  8  FIFO head byte; valid while arrived = 1; 0 when empty.
- read  input  1  pop request; pops the head on a rising Clock edge when arrived = 1; ignored when empty.
- overrun  output  1  sticky: a valid byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a frame was discarded because its stop bit was 0.
- clear_err  input  1  clears overrun and frame_err on the next edge; a set event in the same cycle wins.

## Operation
- RX passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- One bit-timing counter (width clog2(CLKS_PER_BIT)); H = floor(CLKS_PER_BIT/2).
- States:
  - IDLE: rx_s = 0 → START, counter cleared.
  - START: rx_s is sampled H cycles after entry. 0 → DATA, counter cleared. 1 → IDLE; this is a glitch, with no flag and no push.
  - DATA: rx_s is sampled every CLKS_PER_BIT cycles into the shift register, LSB first. After the 8th sample → STOP.
  - STOP: rx_s is sampled CLKS_PER_BIT cycles after the 8th data sample. 1 → push the byte, then IDLE. 0 → set frame_err, discard the byte, → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then → IDLE. A held-low break therefore produces exactly one frame_err.
- FIFO:
  - Circular buffer of 2^DEPTH_LOG2 entries.
  - Read and write pointers are DEPTH_LOG2 bits and wrap naturally.
  - Occupancy count is DEPTH_LOG2+1 bits.
- Push is accepted when count < depth, or when count = depth and a pop occurs in the same cycle. Otherwise the byte is dropped and overrun is set.
- Simultaneous push and pop: both pointers advance and the count is unchanged.
- Pop and push never corrupt the head. data always reflects the entry at the read pointer after the edge.

## Timing
- Reset values:
  - State IDLE, counter 0, pointers 0, count 0, shift register 0.
  - arrived = 0, data = 0, overrun = 0, frame_err = 0.
- T0 is the first cycle in which IDLE sees rx_s = 0. This is 2–3 cycles after the RX pin falls.
- Start sample at T0+H. Data bit i (0..7) is sampled at T0+H+(i+1)·CLKS_PER_BIT. Stop sample at T0+H+9·CLKS_PER_BIT.
- The push occurs on the stop-sample edge. arrived and data are visible in the following cycle.
- frame_err is set on the stop-sample edge. overrun is set on the stop-sample edge when the push is rejected.
- Pop takes effect on the edge where read = 1. arrived drops on the next cycle if the FIFO becomes empty.
- The receiver accepts a new start bit in IDLE immediately after a successful stop sample. Back-to-back frames with a full 1-bit stop period are supported.
- Reset mid-frame aborts the frame and empties the FIFO. The next full frame after reset is received correctly.

## Test plan
All scenarios use CLKS_PER_BIT = 8 and DEPTH_LOG2 = 2, with frames driven at exactly 8 cycles per bit.
1. Reset asserted, then released with RX = 1 → arrived = 0, data = 0x00, overrun = 0, frame_err = 0. No state change for 100 cycles.
2. Frame 0xA5 → arrived rises 1 cycle after the stop sample (T0+76), with data = 0xA5. Pulse read for 1 cycle → arrived = 0 next cycle.
3. RX low for 2 cycles, then high → no push, no flags, state returns to IDLE. A subsequent frame 0x3C is received as 0x3C.
4. Frame 0x55 with stop bit 0, RX then held low 40 cycles, then high → frame_err = 1 once, FIFO empty. Next frame 0x81 is received. Pulse clear_err → frame_err = 0.
5. Frames 0x01–0x05 back-to-back, no reads → FIFO holds 0x01, 0x02, 0x03, 0x04 and overrun = 1. Drain 4 reads → 0x01..0x04 in order, then arrived = 0.
6. Fill FIFO with 4 frames, then assert read on the 5th frame's stop-sample cycle → no overrun. Contents are 0x02..0x05. Separately, assert Reset mid-data-bits → all outputs are at reset values and the next frame 0xF0 is received correctly.
